// File: rtl/drive_pkg.sv
// ---------------------------------------------------------------------------
// drive_pkg
// Shared definitions for the drive arbitration slice.
//   drive_dir_t  : 4-bit motor direction code (codes 9..15 are not legal
//                  directions and are folded to STOP by sanitize_dir)
//   KEY_*        : Arduino key bytes understood by the manual decoder
//   arb_state_t  : arbiter FSM states
//   dir_group    : classifies a direction as forward, backward or neither
//   is_reversal  : true when a move crosses between forward and backward
// ---------------------------------------------------------------------------
package drive_pkg;

  typedef enum logic [3:0] {
    STOP  = 4'd0,
    FWD   = 4'd1,
    BWD   = 4'd2,
    LEFT  = 4'd3,
    RIGHT = 4'd4,
    FWD_L = 4'd5,
    FWD_R = 4'd6,
    BWD_L = 4'd7,
    BWD_R = 4'd8
  } drive_dir_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEADTIME,
    TIMEOUT
  } arb_state_t;

  // Arduino key bytes; two different keys both mean plain forward.
  localparam logic [7:0] KEY_FWD     = 8'h01;
  localparam logic [7:0] KEY_FWD_ALT = 8'h0A;
  localparam logic [7:0] KEY_BWD     = 8'h04;
  localparam logic [7:0] KEY_LEFT    = 8'h02;
  localparam logic [7:0] KEY_RIGHT   = 8'h08;
  localparam logic [7:0] KEY_FWD_L   = 8'h03;
  localparam logic [7:0] KEY_FWD_R   = 8'h09;
  localparam logic [7:0] KEY_BWD_L   = 8'h06;
  localparam logic [7:0] KEY_BWD_R   = 8'h0C;

  // Folds the unused codes 9..15 onto STOP so nothing illegal reaches a motor.
  function automatic drive_dir_t sanitize_dir(logic [3:0] code);
    if (code > 4'd8) begin
      return STOP;
    end
    return drive_dir_t'(code);
  endfunction

  // 1 = forward group, 2 = backward group, 0 = stop or pure turn.
  function automatic logic [1:0] dir_group(drive_dir_t d);
    case (d)
      FWD, FWD_L, FWD_R: return 2'd1;
      BWD, BWD_L, BWD_R: return 2'd2;
      default:           return 2'd0;
    endcase
  endfunction

  // Only a jump straight between the forward and backward groups needs the
  // motors to coast; turns and stops never count as a reversal.
  function automatic logic is_reversal(drive_dir_t from_dir, drive_dir_t to_dir);
    logic [1:0] g_from;
    logic [1:0] g_to;
    g_from = dir_group(from_dir);
    g_to   = dir_group(to_dir);
    return (g_from != 2'd0) && (g_to != 2'd0) && (g_from != g_to);
  endfunction

endpackage

// File: rtl/drive_cmd_decode.sv
// ---------------------------------------------------------------------------
// drive_cmd_decode
// Purely combinational translation of an Arduino key byte into a direction.
// Ports:
//   i_cmd [7:0] : raw key byte from the manual controller
//   o_dir [3:0] : decoded drive_dir_t code; unknown bytes give STOP
// ---------------------------------------------------------------------------
module drive_cmd_decode
  import drive_pkg::*;
(
  input  logic [7:0] i_cmd,
  output logic [3:0] o_dir
);

  drive_dir_t w_dir;

  // Any byte that is not a known key deliberately falls through to STOP.
  always_comb begin
    w_dir = STOP;
    case (i_cmd)
      KEY_FWD, KEY_FWD_ALT: w_dir = FWD;
      KEY_BWD:              w_dir = BWD;
      KEY_LEFT:             w_dir = LEFT;
      KEY_RIGHT:            w_dir = RIGHT;
      KEY_FWD_L:            w_dir = FWD_L;
      KEY_FWD_R:            w_dir = FWD_R;
      KEY_BWD_L:            w_dir = BWD_L;
      KEY_BWD_R:            w_dir = BWD_R;
      default:              w_dir = STOP;
    endcase
  end

  assign o_dir = w_dir;

endmodule

// File: rtl/drive_arbiter.sv
// ---------------------------------------------------------------------------
// drive_arbiter
// Chooses between the manual (Arduino) and autonomous drive sources, inserts
// a forced-stop deadtime on direction reversals and source changes, and stops
// the motors when the manual source goes quiet for too long.
// Parameters:
//   TIMEOUT_CYCLES  : manual watchdog period in clocks (2..2^24-1)
//   DEADTIME_CYCLES : forced-stop length in clocks (1..2^20-1)
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset
//   manual_on     : 1 = manual source selected, 0 = autonomous
//   manual_cmd    : Arduino key byte, qualified by manual_valid
//   manual_valid  : one-cycle strobe for manual_cmd
//   auto_dir      : autonomous direction code, qualified by auto_valid
//   auto_valid    : one-cycle strobe for auto_dir
//   motor_dir     : registered direction applied to the motors
//   src_manual    : registered; 1 while the manual source owns the motors
//   timeout_fault : registered; 1 while the manual watchdog has expired
// ---------------------------------------------------------------------------
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 5_000_000,
  parameter int unsigned DEADTIME_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       manual_on,
  input  logic [7:0] manual_cmd,
  input  logic       manual_valid,
  input  logic [3:0] auto_dir,
  input  logic       auto_valid,
  output logic [3:0] motor_dir,
  output logic       src_manual,
  output logic       timeout_fault
);

  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] WD_MAX  = 24'(TIMEOUT_CYCLES);
  localparam logic [19:0] DT_LAST = 20'(DEADTIME_CYCLES - 1);

  arb_state_t  r_state;
  drive_dir_t  r_motor_dir;
  drive_dir_t  r_pending;
  drive_dir_t  r_prev_dir;
  logic [19:0] r_dead_cnt;
  logic [23:0] r_wd_cnt;
  logic        r_timeout_fault;
  logic        r_src_manual;

  arb_state_t  w_state_n;
  drive_dir_t  w_motor_dir_n;
  drive_dir_t  w_pending_n;
  drive_dir_t  w_prev_dir_n;
  logic [19:0] w_dead_cnt_n;
  logic [23:0] w_wd_cnt_n;
  logic        w_timeout_fault_n;
  logic        w_src_manual_n;

  logic [3:0]  w_manual_code;
  drive_dir_t  w_manual_dir;
  drive_dir_t  w_cmd;
  drive_dir_t  w_release_dir;
  logic        w_accept;
  logic        w_src_change;
  logic        w_wd_expired;

  drive_cmd_decode u_decode (
    .i_cmd (manual_cmd),
    .o_dir (w_manual_code)
  );

  // Only the strobe of the source that currently owns the motors is heard.
  // During the cycle manual_on flips, the source change wins and any strobe
  // is dropped because pending is cleared anyway.
  assign w_manual_dir = sanitize_dir(w_manual_code);
  assign w_src_change = (manual_on != r_src_manual);
  assign w_accept     = r_src_manual ? manual_valid : auto_valid;
  assign w_cmd        = r_src_manual ? w_manual_dir : sanitize_dir(auto_dir);
  assign w_wd_expired = r_src_manual && !w_accept && (r_wd_cnt == WD_LAST)
                        && (r_state != TIMEOUT);

  // State register; reset also re-samples the source select so the arbiter
  // comes up owned by whichever source is already selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_motor_dir     <= STOP;
      r_pending       <= STOP;
      r_prev_dir      <= STOP;
      r_dead_cnt      <= '0;
      r_wd_cnt        <= '0;
      r_timeout_fault <= 1'b0;
      r_src_manual    <= manual_on;
    end else begin
      r_state         <= w_state_n;
      r_motor_dir     <= w_motor_dir_n;
      r_pending       <= w_pending_n;
      r_prev_dir      <= w_prev_dir_n;
      r_dead_cnt      <= w_dead_cnt_n;
      r_wd_cnt        <= w_wd_cnt_n;
      r_timeout_fault <= w_timeout_fault_n;
      r_src_manual    <= w_src_manual_n;
    end
  end

  // Next-state logic. Priority: source change, then watchdog expiry, then
  // the per-state command handling. Counters only move toward a ceiling
  // they are never allowed to pass.
  always_comb begin
    w_state_n         = r_state;
    w_motor_dir_n     = r_motor_dir;
    w_pending_n       = r_pending;
    w_prev_dir_n      = r_prev_dir;
    w_dead_cnt_n      = r_dead_cnt;
    w_timeout_fault_n = r_timeout_fault;
    w_src_manual_n    = r_src_manual;
    w_release_dir     = w_accept ? w_cmd : r_pending;

    if (!r_src_manual || w_accept) begin
      w_wd_cnt_n = '0;
    end else if (r_wd_cnt < WD_MAX) begin
      w_wd_cnt_n = r_wd_cnt + 24'd1;
    end else begin
      w_wd_cnt_n = r_wd_cnt;
    end

    if (w_src_change) begin
      w_src_manual_n    = manual_on;
      w_pending_n       = STOP;
      w_motor_dir_n     = STOP;
      w_dead_cnt_n      = '0;
      w_wd_cnt_n        = '0;
      w_timeout_fault_n = 1'b0;
      w_state_n         = DEADTIME;
    end else if (w_wd_expired) begin
      // Remember what was running so a post-timeout reversal is still caught.
      w_prev_dir_n      = r_motor_dir;
      w_motor_dir_n     = STOP;
      w_timeout_fault_n = 1'b1;
      w_wd_cnt_n        = WD_MAX;
      w_state_n         = TIMEOUT;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (w_accept) begin
            if (is_reversal(r_motor_dir, w_cmd)) begin
              w_motor_dir_n = STOP;
              w_pending_n   = w_cmd;
              w_dead_cnt_n  = '0;
              w_state_n     = DEADTIME;
            end else begin
              w_motor_dir_n = w_cmd;
              w_state_n     = (w_cmd == STOP) ? IDLE : RUN;
            end
          end
        end
        DEADTIME: begin
          // A newer command replaces pending but does not restart the stop.
          if (w_accept) begin
            w_pending_n = w_cmd;
          end
          if (r_dead_cnt >= DT_LAST) begin
            w_motor_dir_n = w_release_dir;
            w_pending_n   = STOP;
            w_dead_cnt_n  = '0;
            w_state_n     = (w_release_dir == STOP) ? IDLE : RUN;
          end else begin
            w_dead_cnt_n = r_dead_cnt + 20'd1;
          end
        end
        TIMEOUT: begin
          if (w_accept) begin
            w_timeout_fault_n = 1'b0;
            if (is_reversal(r_prev_dir, w_cmd)) begin
              w_motor_dir_n = STOP;
              w_pending_n   = w_cmd;
              w_dead_cnt_n  = '0;
              w_state_n     = DEADTIME;
            end else begin
              w_motor_dir_n = w_cmd;
              w_state_n     = (w_cmd == STOP) ? IDLE : RUN;
            end
          end
        end
        default: begin
          w_state_n     = IDLE;
          w_motor_dir_n = STOP;
        end
      endcase
    end
  end

  assign motor_dir     = r_motor_dir;
  assign src_manual    = r_src_manual;
  assign timeout_fault = r_timeout_fault;

endmodule

// File: tb/tb_drive_arbiter.sv
// ---------------------------------------------------------------------------
// tb_drive_arbiter
// Drives directed scenarios followed by random traffic into drive_arbiter.
// A behavioural model tracks absolute cycle numbers (when the last manual
// key arrived, when a forced stop ends) and pushes the expected outputs for
// every clock into a queue; an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_drive_arbiter;

  localparam int DEAD = 4;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       manual_on;
  logic [7:0] manual_cmd;
  logic       manual_valid;
  logic [3:0] auto_dir;
  logic       auto_valid;
  logic [3:0] motor_dir;
  logic       src_manual;
  logic       timeout_fault;

  typedef struct {
    int motor;
    int src;
    int fault;
    int cycle;
  } expect_t;

  expect_t expQ[$];
  int assertCount = 0;
  int failCount   = 0;

  // Model state, expressed as absolute cycle stamps rather than counters.
  int keyMap[256];
  int mApplied, mPending, mPreFault, mDeadUntil, mLastKey, cycleNo;
  bit mSrc, mFault, mInDead;
  logic monLevel;

  always #5 clk = ~clk;

  drive_arbiter #(
    .TIMEOUT_CYCLES  (TMO),
    .DEADTIME_CYCLES (DEAD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .manual_on     (manual_on),
    .manual_cmd    (manual_cmd),
    .manual_valid  (manual_valid),
    .auto_dir      (auto_dir),
    .auto_valid    (auto_valid),
    .motor_dir     (motor_dir),
    .src_manual    (src_manual),
    .timeout_fault (timeout_fault)
  );

  // Forward = 1, backward = 2, anything else = 0.
  function automatic int groupOf(int d);
    if (d == 1 || d == 5 || d == 6) return 1;
    if (d == 2 || d == 7 || d == 8) return 2;
    return 0;
  endfunction

  function automatic bit reverses(int a, int b);
    return (groupOf(a) != 0) && (groupOf(b) != 0) && (groupOf(a) != groupOf(b));
  endfunction

  function automatic void startStop(int cmd, int n);
    mApplied   = 0;
    mPending   = cmd;
    mInDead    = 1'b1;
    mDeadUntil = n + DEAD;
  endfunction

  // Advances the model by the clock edge that samples these inputs.
  function automatic void modelStep(logic rst, logic mon, logic [7:0] mcmd,
                                    logic mval, logic [3:0] adir, logic aval);
    int n;
    bit accept;
    int cmd;
    n = cycleNo;
    if (rst) begin
      mApplied = 0; mPending = 0; mInDead = 0; mFault = 0;
      mSrc = mon; mLastKey = n;
    end else if (mon != mSrc) begin
      mSrc = mon; mFault = 0; mLastKey = n;
      startStop(0, n);
    end else begin
      accept = mSrc ? mval : aval;
      cmd    = mSrc ? keyMap[int'(mcmd)] : ((int'(adir) > 8) ? 0 : int'(adir));
      if (accept && mSrc) mLastKey = n;
      if (mSrc && !mFault && (n - mLastKey >= TMO)) begin
        mFault = 1; mPreFault = mApplied; mApplied = 0; mInDead = 0;
      end else if (mFault) begin
        if (accept) begin
          mFault = 0;
          if (reverses(mPreFault, cmd)) startStop(cmd, n);
          else mApplied = cmd;
        end
      end else if (mInDead) begin
        if (accept) mPending = cmd;
        if (n >= mDeadUntil) begin
          mApplied = mPending;
          mInDead  = 0;
        end
      end else if (accept) begin
        if (reverses(mApplied, cmd)) startStop(cmd, n);
        else mApplied = cmd;
      end
    end
  endfunction

  // Drives one clock's worth of inputs and queues what the DUT must show.
  task automatic applyStimulus(input logic rst, input logic mon,
                               input logic [7:0] mcmd, input logic mval,
                               input logic [3:0] adir, input logic aval);
    expect_t e;
    @(negedge clk);
    reset        = rst;
    manual_on    = mon;
    manual_cmd   = mcmd;
    manual_valid = mval;
    auto_dir     = adir;
    auto_valid   = aval;
    cycleNo++;
    modelStep(rst, mon, mcmd, mval, adir, aval);
    e.motor = mApplied;
    e.src   = int'(mSrc);
    e.fault = int'(mFault);
    e.cycle = cycleNo;
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int count);
    repeat (count) applyStimulus(1'b0, monLevel, 8'h00, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic manualKey(input logic [7:0] key);
    applyStimulus(1'b0, monLevel, key, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic autoCmd(input logic [3:0] dir);
    applyStimulus(1'b0, monLevel, 8'h00, 1'b0, dir, 1'b1);
  endtask

  task automatic checkOutput(input string name, input int got, input int want,
                             input int cyc);
    assertCount++;
    if (got != want) begin
      failCount++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  // Monitor: the DUT presents new registered outputs after every rising edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("motor_dir", int'(motor_dir), e.motor, e.cycle);
        checkOutput("src_manual", int'(src_manual), e.src, e.cycle);
        checkOutput("timeout_fault", int'(timeout_fault), e.fault, e.cycle);
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    logic [7:0] keyList[10];
    logic       rst, mval, aval;
    logic [7:0] mcmd;
    int         quietLeft;

    for (int i = 0; i < 256; i++) keyMap[i] = 0;
    keyMap[8'h01] = 1; keyMap[8'h0A] = 1; keyMap[8'h04] = 2;
    keyMap[8'h02] = 3; keyMap[8'h08] = 4; keyMap[8'h03] = 5;
    keyMap[8'h09] = 6; keyMap[8'h06] = 7; keyMap[8'h0C] = 8;
    keyList = '{8'h01, 8'h0A, 8'h04, 8'h02, 8'h08, 8'h03, 8'h09, 8'h06, 8'h0C, 8'h00};

    cycleNo = 0; mApplied = 0; mPending = 0; mPreFault = 0;
    mDeadUntil = 0; mLastKey = 0; mSrc = 1; mFault = 0; mInDead = 0;
    reset = 1'b1; manual_on = 1'b1; manual_cmd = 8'h00;
    manual_valid = 1'b0; auto_dir = 4'd0; auto_valid = 1'b0;
    monLevel = 1'b1;

    $display("[TB] reset and manual forward/diagonal");
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
    idleCycles(1);
    manualKey(8'h0A);
    idleCycles(1);
    manualKey(8'h03);
    idleCycles(2);

    $display("[TB] reversal with pending overwrite");
    manualKey(8'h01);
    idleCycles(2);
    manualKey(8'h04);
    idleCycles(1);
    manualKey(8'h0C);
    idleCycles(5);

    $display("[TB] manual watchdog");
    manualKey(8'h01);
    idleCycles(22);
    manualKey(8'h01);
    idleCycles(2);

    $display("[TB] source change to autonomous");
    monLevel = 1'b0;
    idleCycles(5);
    applyStimulus(1'b0, 1'b0, 8'h04, 1'b1, 4'd4, 1'b1);
    idleCycles(2);

    $display("[TB] reset during deadtime");
    autoCmd(4'd1);
    idleCycles(1);
    autoCmd(4'd2);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
    idleCycles(6);

    $display("[TB] illegal codes");
    monLevel = 1'b1;
    idleCycles(5);
    manualKey(8'h09);
    manualKey(8'hFF);
    manualKey(8'h06);
    manualKey(8'h00);
    idleCycles(1);
    monLevel = 1'b0;
    idleCycles(5);
    autoCmd(4'd3);
    autoCmd(4'd12);
    autoCmd(4'd9);
    idleCycles(2);

    $display("[TB] random traffic");
    quietLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 79) == 0) monLevel = ~monLevel;
      if (quietLeft == 0 && $urandom_range(0, 99) == 0) quietLeft = 25;
      if (quietLeft > 0) begin
        quietLeft--;
        mval = 1'b0;
      end else begin
        mval = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 9) < 7) mcmd = keyList[$urandom_range(0, 9)];
      else mcmd = 8'($urandom_range(0, 255));
      aval = ($urandom_range(0, 3) == 0);
      applyStimulus(rst, monLevel, mcmd, mval, 4'($urandom_range(0, 15)), aval);
    end
    idleCycles(2);

    repeat (3) @(posedge clk);
    #2;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL queue_drain: got %0d entries left expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/drive_arbiter.md
DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5_000_000: manual-command watchdog period (100 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter DEADTIME_CYCLES, default 50_000: forced-stop cycles on reversal or source change; legal range 1..2^20-1.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port manual_on, input, 1: 1 selects the manual (Arduino) source, 0 selects the autonomous source.
REQ-006 SHALL have port manual_cmd, input, 8: Arduino key byte.
REQ-007 SHALL have port manual_valid, input, 1: one-cycle strobe qualifying manual_cmd.
REQ-008 SHALL have port auto_dir, input, 4: autonomous direction code (drive_dir_t).
REQ-009 SHALL have port auto_valid, input, 1: one-cycle strobe qualifying auto_dir.
REQ-010 SHALL have port motor_dir, output, 4: registered applied direction (drive_dir_t).
REQ-011 SHALL have port src_manual, output, 1: registered; 1 when the manual source currently owns the motors.
REQ-012 SHALL have port timeout_fault, output, 1: registered; high while the manual watchdog has expired.

Function
REQ-013 SHALL use drive_dir_t codes: STOP=0, FWD=1, BWD=2, LEFT=3, RIGHT=4, FWD_L=5, FWD_R=6, BWD_L=7, BWD_R=8; codes 9..15 SHALL be treated as STOP.
REQ-014 SHALL decode manual_cmd as follows: 0x01 or 0x0A to FWD, 0x04 to BWD, 0x02 to LEFT, 0x08 to RIGHT, 0x03 to FWD_L, 0x09 to FWD_R, 0x06 to BWD_L, 0x0C to BWD_R; every other value decodes to STOP.
REQ-015 SHALL accept only the strobe of the selected source; the strobe of the unselected source SHALL be ignored, including when both strobes arrive in the same cycle.
REQ-016 SHALL implement the FSM states IDLE, RUN, DEADTIME and TIMEOUT.
REQ-017 SHALL, in IDLE on an accepted command, go to RUN and apply it, except that a STOP command keeps the FSM in IDLE.
REQ-018 SHALL, in RUN, apply an accepted command on motor_dir one cycle after its strobe (latency 1), except when the command is a reversal.
REQ-019 SHALL define a reversal as any change between the forward group {FWD, FWD_L, FWD_R} and the backward group {BWD, BWD_L, BWD_R}.
REQ-020 SHALL, on a reversal, drive motor_dir=STOP, latch the new command as pending, and enter DEADTIME.
REQ-021 SHALL, in DEADTIME, hold motor_dir=STOP for exactly DEADTIME_CYCLES cycles, then apply pending and go to RUN (or to IDLE if pending is STOP).
REQ-022 SHALL overwrite pending with any newer command accepted during DEADTIME, without restarting the count.
REQ-023 SHALL, on any change of manual_on, latch it into src_manual, clear pending to STOP, and enter DEADTIME from any state; a change occurring during DEADTIME SHALL restart the count.
REQ-024 SHALL, while src_manual=1, count cycles since the last accepted manual_valid; at TIMEOUT_CYCLES it SHALL drive motor_dir=STOP, set timeout_fault=1, and enter TIMEOUT.
REQ-025 SHALL exit TIMEOUT on the next accepted manual_valid, clearing timeout_fault and applying the command, with no deadtime unless the command is a reversal relative to the pre-timeout direction; exit by source change SHALL follow REQ-023.
REQ-026 SHALL hold the watchdog counter at 0 and keep timeout_fault low while src_manual=0.
REQ-027 SHALL saturate all counters and never let them wrap.

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, motor_dir=STOP, pending=STOP, all counters to 0, timeout_fault=0, and src_manual=manual_on (sampled); reset SHALL take priority over every event, including mid-DEADTIME.

Structure
REQ-029 SHALL take drive_dir_t, the manual key-byte constants, and the FSM state enum from the shared package drive_pkg.
REQ-030 SHALL instantiate the manual byte decode as the combinational sub-module drive_cmd_decode (manual_cmd to drive_dir_t).

Verification (DEADTIME_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-031 SHALL verify: manual_on=1, manual_valid with 0x0A -> motor_dir=FWD on the next cycle; then 0x03 -> FWD_L on the next cycle.
REQ-032 SHALL verify: in FWD, manual 0x04 -> STOP for 4 cycles, then BWD; a 0x0C strobe during that window -> BWD_R after the same 4 cycles.
REQ-033 SHALL verify: manual_on=1 with no strobe for 20 cycles -> timeout_fault=1 and motor_dir=STOP; then 0x01 -> fault clears and FWD on the next cycle.
REQ-034 SHALL verify: manual_on 1->0 while in FWD -> STOP for 4 cycles and src_manual=0; an auto_valid with RIGHT then -> RIGHT; a manual_valid in the same cycle is ignored.
REQ-035 SHALL verify: reset asserted in cycle 2 of DEADTIME -> motor_dir=STOP and IDLE on the next cycle, with no pending command applied afterwards.
REQ-036 SHALL verify: manual bytes 0xFF and 0x00 -> STOP; auto_dir=12 -> STOP.
